mult_seq_ctrl: RTL and testbench
================================

MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 SHALL have parameter MY_WIDTH, default 9: multiplier operand width, which is also the iteration count; legal range 2..64.
REQ-002 SHALL have parameter SKIP_ZERO, default 0: when 1, suppress the accumulator add for zero multiplier bits.
REQ-003 SHALL have port CLK, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port START, input, 1 bit: request a new multiplication; sampled only in IDLE or DONE.
REQ-006 SHALL have port ABORT, input, 1 bit: cancel an in-progress multiplication.
REQ-007 SHALL have port SIGNED_MODE, input, 1 bit: two's-complement multiplier; sampled with START.
REQ-008 SHALL have port MY_LSB, input, 1 bit: current LSB of the multiplier shift register.
REQ-009 SHALL have output ports LOAD_MX, LOAD_MY, SHIFT_MY, CLEAR_ACC, LOAD_ACC, SHIFT_IN, each 1 bit: datapath controls.
REQ-010 SHALL have port SUB_ACC, output, 1 bit: datapath subtracts instead of adds during the current LOAD_ACC.
REQ-011 SHALL have port BUSY, output, 1 bit: high in LOAD and ITER.
REQ-012 SHALL have port DONE, output, 1 bit: one-cycle pulse; the product is valid in the datapath.
REQ-013 SHALL have port ITER_CNT, output, width clog2(MY_WIDTH), value: remaining iterations minus 1.

Function
REQ-014 SHALL implement a four-state FSM: IDLE, LOAD, ITER, DONE.
REQ-015 IDLE: START=1 and ABORT=0 -> LOAD next cycle, with SIGNED_MODE latched; otherwise stay in IDLE.
REQ-016 LOAD lasts exactly one cycle and asserts LOAD_MX, LOAD_MY and CLEAR_ACC; ITER_CNT loads MY_WIDTH-1; next state ITER.
REQ-017 ITER asserts SHIFT_MY and SHIFT_IN every cycle; ITER_CNT decrements each cycle; ITER lasts exactly MY_WIDTH cycles.
REQ-018 ITER LOAD_ACC: equals 1 when SKIP_ZERO=0; equals MY_LSB when SKIP_ZERO=1 (same-cycle combinational dependency on MY_LSB).
REQ-019 SUB_ACC SHALL equal LOAD_ACC & latched SIGNED_MODE & (ITER_CNT==0), and SHALL be 0 in all other cycles.
REQ-020 Leaving ITER: when ITER_CNT==0 in ITER, next state is DONE; ITER_CNT does not wrap.
REQ-021 DONE lasts one cycle with DONE=1; START=1 in DONE -> LOAD next cycle (back-to-back operation); otherwise IDLE.
REQ-022 Latency: START seen at cycle n -> LOAD at n+1, ITER at n+2..n+MY_WIDTH+1, DONE at n+MY_WIDTH+2.
REQ-023 START while BUSY=1 SHALL be ignored.
REQ-024 ABORT in LOAD or ITER -> IDLE next cycle with no DONE pulse; ABORT has priority over completion in the same cycle.
REQ-025 ABORT and START together in IDLE or DONE: ABORT wins; no operation starts.
REQ-026 Apart from LOAD_ACC and SUB_ACC, all outputs SHALL be decoded from registered state and counter only, with no combinational path from START or ABORT.
REQ-027 In IDLE, all control outputs, BUSY and DONE SHALL be 0.

Reset
REQ-028 RST=1 at a rising edge SHALL force IDLE, ITER_CNT=0 and latched SIGNED_MODE=0, so that every output is 0 in the following cycle.
REQ-029 RST SHALL take priority over START and ABORT, and a reset in mid-operation SHALL produce no DONE pulse.

Structure
REQ-030 Package mult_ctrl_pkg SHALL hold the state typedef (2-bit encoding: IDLE=0, LOAD=1, ITER=2, DONE=3) and a clog2 width function.
REQ-031 The down-counter SHALL be a sub-module mult_iter_cnt (load, decrement, zero flag, WIDTH parameter); the FSM and output decode SHALL stay in mult_seq_ctrl.

Verification
REQ-032 Unsigned, MY_WIDTH=9: MX=0xFFFF, MY=0x1FF, START pulse -> DONE 11 cycles later; exactly 9 SHIFT_MY cycles; product 0x1FEFE01 checked against a datapath model.
REQ-033 Signed, MY_WIDTH=4: MX=3, MY=-2 (0xE), SIGNED_MODE=1 -> SUB_ACC high only in the 4th ITER cycle; product -6.
REQ-034 SKIP_ZERO=1, MY=0b101000000 -> LOAD_ACC high in exactly 2 of 9 ITER cycles; product equals MX*320.
REQ-035 ABORT asserted in the 3rd ITER cycle -> IDLE next cycle, no DONE; then a new START completes normally.
REQ-036 START held high through DONE -> LOAD immediately follows DONE; 2 products in 2*(MY_WIDTH+2) cycles; START pulses while BUSY are ignored.
REQ-037 RST asserted in mid-ITER -> all outputs 0 the next cycle; RST together with START -> remains in IDLE.

Source files
------------

// File: rtl/mult_ctrl_pkg.sv
// rtl/mult_ctrl_pkg.sv - shared state encoding and width helper for the multiplier sequencer
package mult_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ITER = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Ceiling log2, never below 1 so a counter port always has at least one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mult_iter_cnt.sv
// rtl/mult_iter_cnt.sv - loadable saturating down-counter with zero flag
module mult_iter_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] cnt,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Decrement stops at zero so the count never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - shift-add multiplier sequencer: FSM and datapath control decode
module mult_seq_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int MY_WIDTH  = 9,
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              START,
    input  logic                              ABORT,
    input  logic                              SIGNED_MODE,
    input  logic                              MY_LSB,
    output logic                              LOAD_MX,
    output logic                              LOAD_MY,
    output logic                              SHIFT_MY,
    output logic                              CLEAR_ACC,
    output logic                              LOAD_ACC,
    output logic                              SHIFT_IN,
    output logic                              SUB_ACC,
    output logic                              BUSY,
    output logic                              DONE,
    output logic [cnt_width(MY_WIDTH)-1:0]    ITER_CNT
);

    localparam int            CW       = cnt_width(MY_WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(MY_WIDTH - 1);

    state_e        state_q;
    state_e        state_d;
    logic          signed_q;
    logic          signed_d;
    logic          cnt_load;
    logic [CW-1:0] cnt_load_val;
    logic          cnt_dec;
    logic          cnt_zero;
    logic [CW-1:0] cnt_val;

    always_comb begin
        state_d      = state_q;
        signed_d     = signed_q;
        cnt_load     = 1'b0;
        cnt_load_val = LAST_IDX;
        cnt_dec      = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START && !ABORT) begin
                    state_d  = ST_LOAD;
                    signed_d = SIGNED_MODE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                cnt_load = 1'b1;
                if (ABORT) begin
                    state_d      = ST_IDLE;
                    cnt_load_val = '0;
                end else begin
                    state_d = ST_ITER;
                end
            end
            ST_ITER: begin
                // Abort outranks completion when both land on the last iteration.
                if (ABORT) begin
                    state_d      = ST_IDLE;
                    cnt_load     = 1'b1;
                    cnt_load_val = '0;
                end else begin
                    cnt_dec = 1'b1;
                    if (cnt_zero) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            signed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            signed_q <= signed_d;
        end
    end

    mult_iter_cnt #(
        .WIDTH(CW)
    ) u_iter_cnt (
        .clk      (CLK),
        .rst      (RST),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .cnt      (cnt_val),
        .zero     (cnt_zero)
    );

    logic in_load;
    logic in_iter;

    assign in_load = (state_q == ST_LOAD);
    assign in_iter = (state_q == ST_ITER);

    assign LOAD_MX   = in_load;
    assign LOAD_MY   = in_load;
    assign CLEAR_ACC = in_load;
    assign SHIFT_MY  = in_iter;
    assign SHIFT_IN  = in_iter;
    // With zero skipping the add is gated here; otherwise the datapath gates it by the multiplier bit.
    assign LOAD_ACC  = in_iter & (!SKIP_ZERO | MY_LSB);
    // The top multiplier bit carries negative weight in two's complement.
    assign SUB_ACC   = LOAD_ACC & signed_q & cnt_zero;
    assign BUSY      = in_load | in_iter;
    assign DONE      = (state_q == ST_DONE);
    assign ITER_CNT  = cnt_val;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb/tb_mult_seq_ctrl.sv - self-checking bench for mult_seq_ctrl with a shift-add datapath model
module tb_mult_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [2:0]        st;
    logic              abort;
    logic              sgn;
    logic signed [31:0] mx_in;
    logic [31:0]       my_in;

    logic [2:0] lmx, lmy, smy, clr, lacc, sin, sub, busy, done, lsb;
    logic [3:0] cnt_a;
    logic [1:0] cnt_b;
    logic [3:0] cnt_c;

    logic signed [63:0] mxr [3];
    logic signed [63:0] acc [3];
    logic [63:0]        myr [3];

    assign lsb = {myr[2][0], myr[1][0], myr[0][0]};

    mult_seq_ctrl #(.MY_WIDTH(9), .SKIP_ZERO(1'b0)) u_dut_a (
        .CLK(clk), .RST(rst), .START(st[0]), .ABORT(abort), .SIGNED_MODE(sgn), .MY_LSB(lsb[0]),
        .LOAD_MX(lmx[0]), .LOAD_MY(lmy[0]), .SHIFT_MY(smy[0]), .CLEAR_ACC(clr[0]),
        .LOAD_ACC(lacc[0]), .SHIFT_IN(sin[0]), .SUB_ACC(sub[0]), .BUSY(busy[0]),
        .DONE(done[0]), .ITER_CNT(cnt_a)
    );

    mult_seq_ctrl #(.MY_WIDTH(4), .SKIP_ZERO(1'b0)) u_dut_b (
        .CLK(clk), .RST(rst), .START(st[1]), .ABORT(abort), .SIGNED_MODE(sgn), .MY_LSB(lsb[1]),
        .LOAD_MX(lmx[1]), .LOAD_MY(lmy[1]), .SHIFT_MY(smy[1]), .CLEAR_ACC(clr[1]),
        .LOAD_ACC(lacc[1]), .SHIFT_IN(sin[1]), .SUB_ACC(sub[1]), .BUSY(busy[1]),
        .DONE(done[1]), .ITER_CNT(cnt_b)
    );

    mult_seq_ctrl #(.MY_WIDTH(9), .SKIP_ZERO(1'b1)) u_dut_c (
        .CLK(clk), .RST(rst), .START(st[2]), .ABORT(abort), .SIGNED_MODE(sgn), .MY_LSB(lsb[2]),
        .LOAD_MX(lmx[2]), .LOAD_MY(lmy[2]), .SHIFT_MY(smy[2]), .CLEAR_ACC(clr[2]),
        .LOAD_ACC(lacc[2]), .SHIFT_IN(sin[2]), .SUB_ACC(sub[2]), .BUSY(busy[2]),
        .DONE(done[2]), .ITER_CNT(cnt_c)
    );

    // Shift-add datapath: the add is always gated by the current multiplier bit.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (lmx[k]) mxr[k] <= 64'(mx_in);
            else if (sin[k]) mxr[k] <= mxr[k] <<< 1;
            if (lmy[k]) myr[k] <= {32'd0, my_in};
            else if (smy[k]) myr[k] <= myr[k] >> 1;
            if (clr[k]) acc[k] <= '0;
            else if (lacc[k] && myr[k][0]) acc[k] <= sub[k] ? acc[k] - mxr[k] : acc[k] + mxr[k];
        end
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic [2:0] s, input logic a);
        @(negedge clk);
        rst   = r;
        st    = s;
        abort = a;
        #1;
    endtask

    // {LOAD_MX, LOAD_MY, SHIFT_MY, CLEAR_ACC, LOAD_ACC, SHIFT_IN, SUB_ACC, BUSY, DONE}
    function automatic logic [8:0] outs(input int k);
        return {lmx[k], lmy[k], smy[k], clr[k], lacc[k], sin[k], sub[k], busy[k], done[k]};
    endfunction

    localparam logic [8:0] O_IDLE = 9'b000000000;
    localparam logic [8:0] O_LOAD = 9'b110100010;
    localparam logic [8:0] O_ITER = 9'b001011010;
    localparam logic [8:0] O_DONE = 9'b000000001;

    typedef struct {
        logic       start;
        logic       abort;
        logic [8:0] exp;
        logic [3:0] cnt;
    } vec_t;

    vec_t vec [14];

    initial begin
        int sh, it, nsub, sub_at, lat, nl, ndone, nload_after;
        logic got;

        for (int i = 0; i < 14; i++) begin
            vec[i].start = 1'b0;
            vec[i].abort = 1'b0;
            vec[i].exp   = O_IDLE;
            vec[i].cnt   = 4'd0;
        end
        vec[1].start = 1'b1;
        vec[2].exp   = O_LOAD;
        for (int i = 0; i < 9; i++) begin
            vec[3+i].exp = O_ITER;
            vec[3+i].cnt = 4'(8 - i);
        end
        vec[5].start = 1'b1;
        vec[12].exp  = O_DONE;

        rst = 1'b1; st = 3'b000; abort = 1'b0; sgn = 1'b0;
        mx_in = 32'sh0000FFFF; my_in = 32'h1FF;
        repeat (3) @(negedge clk);

        // Unsigned 9-bit run, cycle by cycle.
        sh = 0;
        for (int i = 0; i < 14; i++) begin
            drive(1'b0, {2'b00, vec[i].start}, vec[i].abort);
            chk($sformatf("vec%0d_outs", i), 64'(outs(0)), 64'(vec[i].exp));
            chk($sformatf("vec%0d_cnt", i), 64'(cnt_a), 64'(vec[i].cnt));
            if (smy[0]) sh++;
        end
        chk("unsigned_shift_count", 64'(sh), 64'd9);
        chk("unsigned_product", acc[0], 64'h1FEFE01);

        // Signed 4-bit: 3 * -2.
        mx_in = 32'sd3; my_in = 32'hE; sgn = 1'b1;
        drive(1'b0, 3'b010, 1'b0);
        it = 0; nsub = 0; sub_at = 0; lat = 0; got = 1'b0;
        for (int c = 1; c <= 10 && !got; c++) begin
            drive(1'b0, 3'b000, 1'b0);
            sgn = 1'b0;
            if (smy[1]) it++;
            if (sub[1]) begin nsub++; sub_at = it; end
            if (done[1]) begin got = 1'b1; lat = c; end
        end
        chk("signed_done_seen", 64'(got), 64'd1);
        chk("signed_latency", 64'(lat), 64'd6);
        chk("signed_iters", 64'(it), 64'd4);
        chk("signed_sub_count", 64'(nsub), 64'd1);
        chk("signed_sub_at", 64'(sub_at), 64'd4);
        chk("signed_product", acc[1], -64'sd6);

        // Zero skipping: two set bits in 0b101000000.
        mx_in = 32'sd5; my_in = 32'h140;
        drive(1'b0, 3'b100, 1'b0);
        it = 0; nl = 0; lat = 0; got = 1'b0;
        for (int c = 1; c <= 15 && !got; c++) begin
            drive(1'b0, 3'b000, 1'b0);
            if (smy[2]) it++;
            if (lacc[2]) nl++;
            if (done[2]) begin got = 1'b1; lat = c; end
        end
        chk("skip_latency", 64'(lat), 64'd11);
        chk("skip_iters", 64'(it), 64'd9);
        chk("skip_load_acc_count", 64'(nl), 64'd2);
        chk("skip_product", acc[2], 64'd1600);

        // Abort in the third ITER cycle, then restart.
        mx_in = 32'sd7; my_in = 32'h3;
        drive(1'b0, 3'b001, 1'b0);
        drive(1'b0, 3'b000, 1'b0);
        drive(1'b0, 3'b000, 1'b0);
        drive(1'b0, 3'b000, 1'b0);
        drive(1'b0, 3'b000, 1'b1);
        chk("abort_in_iter3", 64'({outs(0), cnt_a}), 64'({O_ITER, 4'd6}));
        drive(1'b0, 3'b000, 1'b0);
        chk("abort_next_idle", 64'(outs(0)), 64'(O_IDLE));
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            drive(1'b0, 3'b000, 1'b0);
            if (done[0]) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);
        drive(1'b0, 3'b001, 1'b0);
        lat = 0; got = 1'b0;
        for (int c = 1; c <= 15 && !got; c++) begin
            drive(1'b0, 3'b000, 1'b0);
            if (done[0]) begin got = 1'b1; lat = c; end
        end
        chk("restart_latency", 64'(lat), 64'd11);
        chk("restart_product", acc[0], 64'd21);

        // START held high: two back-to-back products.
        mx_in = 32'sd2; my_in = 32'h5;
        drive(1'b0, 3'b001, 1'b0);
        ndone = 0; nload_after = 0; got = 1'b0;
        for (int c = 1; c <= 22; c++) begin
            drive(1'b0, {2'b00, (c < 22)}, 1'b0);
            if (got && lmx[0]) nload_after++;
            got = done[0];
            if (done[0]) begin
                ndone++;
                chk($sformatf("b2b_product_%0d", ndone), acc[0], 64'd10);
            end
        end
        chk("b2b_done_count", 64'(ndone), 64'd2);
        chk("b2b_load_after_done", 64'(nload_after), 64'd1);
        drive(1'b0, 3'b000, 1'b0);
        chk("b2b_then_idle", 64'(outs(0)), 64'(O_IDLE));

        // Reset in mid-ITER.
        drive(1'b0, 3'b001, 1'b0);
        repeat (4) drive(1'b0, 3'b000, 1'b0);
        drive(1'b1, 3'b000, 1'b0);
        drive(1'b0, 3'b000, 1'b0);
        chk("rst_mid_outs", 64'({outs(0), cnt_a}), 64'({O_IDLE, 4'd0}));
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            drive(1'b0, 3'b000, 1'b0);
            if (done[0]) ndone++;
        end
        chk("rst_mid_no_done", 64'(ndone), 64'd0);

        // Reset beats START; ABORT beats START.
        drive(1'b1, 3'b111, 1'b0);
        drive(1'b0, 3'b000, 1'b0);
        chk("rst_with_start", 64'({outs(0), outs(1), outs(2)}), 64'd0);
        drive(1'b0, 3'b111, 1'b1);
        drive(1'b0, 3'b000, 1'b0);
        chk("abort_with_start", 64'({outs(0), outs(1), outs(2)}), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
